// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED pattern sequencer
//
// Purpose : pattern-mode enum, LED count, per-mode initial patterns and small
//           helpers shared by led_sequencer and its sub-module.
// Ports   : none (package).
package led_seq_pkg;

  localparam int NUM_LEDS = 5;

  // Width of the lit-LED position index (0..NUM_LEDS-1).
  localparam int POS_W = $clog2(NUM_LEDS);

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    BOUNCE = 2'd1,
    COUNT  = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  localparam logic [NUM_LEDS-1:0] INIT_CHASE  = 5'b00001;
  localparam logic [NUM_LEDS-1:0] INIT_BOUNCE = 5'b00001;
  localparam logic [NUM_LEDS-1:0] INIT_COUNT  = 5'b00000;
  localparam logic [NUM_LEDS-1:0] INIT_BLINK  = 5'b11111;

  function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
    logic [NUM_LEDS-1:0] p;
    case (m)
      CHASE:   p = INIT_CHASE;
      BOUNCE:  p = INIT_BOUNCE;
      COUNT:   p = INIT_COUNT;
      default: p = INIT_BLINK;
    endcase
    return p;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      CHASE:   n = BOUNCE;
      BOUNCE:  n = COUNT;
      COUNT:   n = BLINK;
      default: n = CHASE;
    endcase
    return n;
  endfunction

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [POS_W-1:0] pos);
    return {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser and optional counter debouncer
//
// Purpose : bring the raw asynchronous button into the clk100 domain and
//           produce a stable level. Build option SEQ_DEBOUNCE_EN selects a
//           counter-based debouncer; without it the stable level is simply
//           the 2-flop synchronised button.
// Ports   : clk100     - system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           btn_raw    - raw asynchronous button, active-high
//           btn_stable - accepted button level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk100,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_stable
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SEQ_DEBOUNCE_EN

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreement restarts the qualification window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign btn_stable = stable_q;

`else

  // Debounce window has no meaning in this build.
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = (DEBOUNCE_CYCLES != 0);

  assign btn_stable = sync2_q;

`endif

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - five-LED pattern sequencer stepped by a tempo level
//
// Purpose : every transition of tick_in advances the current LED pattern;
//           a button press cycles the pattern mode CHASE -> BOUNCE -> COUNT
//           -> BLINK. Build option SEQ_DEBOUNCE_EN (inside btn_debounce)
//           enables the counter-based button debouncer.
// Ports   : clk100     - 100 MHz system clock, rising edge
//           rst_n      - asynchronous active-low reset
//           tick_in    - tempo level, each edge is one step
//           btn        - raw asynchronous mode button, active-high
//           leds[4:0]  - LED drive, active-high, bit 0 = LED1
//           mode[1:0]  - current pattern mode
//           step_pulse - one-cycle strobe when the pattern advanced
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clk100,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                btn,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode,
  output logic                step_pulse
);

  logic btn_stable;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .btn_raw   (btn),
    .btn_stable(btn_stable)
  );

  // Tempo synchroniser plus history flop for edge detection.
  logic tick_sync1_q, tick_sync2_q, tick_hist_q;
  logic btn_prev_q;

  mode_e               mode_q, mode_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_up_q, dir_up_d;
  logic [NUM_LEDS-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic                step_pulse_q, step_pulse_d;

  logic step;
  logic press;

  assign step  = tick_sync2_q ^ tick_hist_q;
  assign press = btn_stable & ~btn_prev_q;

  // State register.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      tick_sync1_q <= 1'b0;
      tick_sync2_q <= 1'b0;
      tick_hist_q  <= 1'b0;
      btn_prev_q   <= 1'b0;
      mode_q       <= CHASE;
      pos_q        <= '0;
      dir_up_q     <= 1'b1;
      cnt_q        <= '0;
      phase_q      <= 1'b1;
      leds_q       <= INIT_CHASE;
      step_pulse_q <= 1'b0;
    end else begin
      tick_sync1_q <= tick_in;
      tick_sync2_q <= tick_sync1_q;
      tick_hist_q  <= tick_sync2_q;
      btn_prev_q   <= btn_stable;
      mode_q       <= mode_d;
      pos_q        <= pos_d;
      dir_up_q     <= dir_up_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      leds_q       <= leds_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // Next-state logic. A press takes priority; a coincident step is consumed
  // by the history flop and never shows up later.
  always_comb begin
    mode_d       = mode_q;
    pos_d        = pos_q;
    dir_up_d     = dir_up_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    leds_d       = leds_q;
    step_pulse_d = 1'b0;

    if (press) begin
      mode_d   = next_mode(mode_q);
      pos_d    = '0;
      dir_up_d = 1'b1;
      cnt_d    = '0;
      phase_d  = 1'b1;
      leds_d   = init_pattern(next_mode(mode_q));
    end else if (step) begin
      step_pulse_d = 1'b1;
      case (mode_q)
        CHASE: begin
          pos_d  = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + POS_W'(1);
          leds_d = onehot(pos_d);
        end
        BOUNCE: begin
          // Direction flips as the end is reached, so end values show once.
          if (dir_up_q) begin
            pos_d = pos_q + POS_W'(1);
            if (pos_q == POS_W'(NUM_LEDS - 2)) dir_up_d = 1'b0;
          end else begin
            pos_d = pos_q - POS_W'(1);
            if (pos_q == POS_W'(1)) dir_up_d = 1'b1;
          end
          leds_d = onehot(pos_d);
        end
        COUNT: begin
          cnt_d  = cnt_q + NUM_LEDS'(1);
          leds_d = cnt_d;
        end
        default: begin
          phase_d = ~phase_q;
          leds_d  = phase_d ? INIT_BLINK : '0;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    leds       = leds_q;
    mode       = mode_q;
    step_pulse = step_pulse_q;
  end

endmodule
